// File: rtl/tx_msg_sched_1553.sv
// MIL-STD-1553 transmit scheduler: queues host words and feeds them one at a time to the
// Manchester encoder, enforcing the inter-message gap and supervising the encoder handshake.
module tx_msg_sched_1553 #(
    parameter int DEPTH    = 8,
    parameter int GAP_CLKS = 8,
    parameter int BUSY_TO  = 4
) (
    input  logic                   enc_clk,
    input  logic                   rst_n,
    input  logic                   wr_en_i,
    input  logic [15:0]            wr_word_i,
    input  logic                   wr_csw_i,
    input  logic                   wr_eom_i,
    output logic                   wr_full_o,
    output logic [$clog2(DEPTH):0] fifo_cnt_o,
    input  logic                   tx_busy_i,
    output logic [15:0]            tx_dword_o,
    output logic                   tx_csw_o,
    output logic                   tx_dw_o,
    output logic                   msg_done_o,
    output logic                   ovf_err_o,
    output logic                   to_err_o,
    input  logic                   err_clr_i,
    output logic [2:0]             state_dbg_o
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CMAX = (GAP_CLKS > BUSY_TO) ? GAP_CLKS : BUSY_TO;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [17:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [CW-1:0]   tmr_q, tmr_d;
    logic [15:0]     dword_q, dword_d;
    logic            eom_q, eom_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic            to_q, to_d;
    logic            to_set;
    logic            full, empty, push, pop;
    logic [15:0]     head_word;
    logic            head_csw, head_eom;

    // Entry layout is {word, csw, eom}; the head is stable for the whole ISSUE cycle.
    assign full      = (cnt_q == DEPTH_CNT);
    assign empty     = (cnt_q == '0);
    assign push      = wr_en_i && !full;
    assign pop       = (state_q == ISSUE);
    assign head_word = mem_q[rd_ptr_q][17:2];
    assign head_csw  = mem_q[rd_ptr_q][1];
    assign head_eom  = mem_q[rd_ptr_q][0];

    always_ff @(posedge enc_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {wr_word_i, wr_csw_i, wr_eom_i};
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Encoder handshake: a strobe is issued only while tx_busy_i is low; the encoder must raise
    // tx_busy_i within BUSY_TO cycles and drops it once the word has left the bus.
    always_comb begin
        state_d = state_q;
        tmr_d   = '0;
        dword_d = dword_q;
        eom_d   = eom_q;
        done_d  = 1'b0;
        to_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !tx_busy_i) state_d = ISSUE;
            end
            ISSUE: begin
                dword_d = head_word;
                eom_d   = head_eom;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy_i) begin
                    state_d = WAIT_DONE;
                end else if (tmr_q == CW'(BUSY_TO - 1)) begin
                    to_set  = 1'b1;
                    state_d = eom_q ? GAP : IDLE;
                end else begin
                    tmr_d = tmr_q + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy_i) begin
                    state_d = eom_q ? GAP : IDLE;
                    done_d  = eom_q;
                end
            end
            GAP: begin
                if (tmr_q == CW'(GAP_CLKS - 1)) state_d = IDLE;
                else                            tmr_d   = tmr_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // A new error in the same cycle as err_clr_i takes priority over the clear.
    always_comb begin
        ovf_d = ovf_q;
        to_d  = to_q;
        if (err_clr_i) begin
            ovf_d = 1'b0;
            to_d  = 1'b0;
        end
        if (wr_en_i && full) ovf_d = 1'b1;
        if (to_set)          to_d  = 1'b1;
    end

    always_ff @(posedge enc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            tmr_q    <= '0;
            dword_q  <= '0;
            eom_q    <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            dword_q  <= dword_d;
            eom_q    <= eom_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            to_q     <= to_d;
        end
    end

    assign tx_csw_o    = (state_q == ISSUE) && head_csw;
    assign tx_dw_o     = (state_q == ISSUE) && !head_csw;
    assign tx_dword_o  = (state_q == ISSUE) ? head_word : dword_q;
    assign wr_full_o   = full;
    assign fifo_cnt_o  = cnt_q;
    assign msg_done_o  = done_q;
    assign ovf_err_o   = ovf_q;
    assign to_err_o    = to_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_tx_msg_sched_1553.sv
// Bench for tx_msg_sched_1553: scoreboarded strobes, a small encoder busy model,
// and timing checks for latency, message gap, overflow, timeout and reset.
module tb_tx_msg_sched_1553;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;

    logic        enc_clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_en = 1'b0;
    logic [15:0] wr_word = '0;
    logic        wr_csw = 1'b0;
    logic        wr_eom = 1'b0;
    logic        err_clr = 1'b0;
    logic        tx_busy;
    logic        busy_man = 1'b0;
    logic        enc_auto = 1'b0;
    logic        enc_busy = 1'b0;
    logic        enc_next = 1'b0;
    int          enc_len = 0;
    int          enc_rem = 0;

    logic        wr_full;
    logic [3:0]  fifo_cnt;
    logic [15:0] tx_dword;
    logic        tx_csw, tx_dw, msg_done, ovf_err, to_err;
    logic [2:0]  state_dbg;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [16:0] exp_q[$];
    logic [16:0] exp_v;
    int          strobe_log[$];
    int          done_log[$];

    tx_msg_sched_1553 #(.DEPTH(8), .GAP_CLKS(8), .BUSY_TO(4)) dut (
        .enc_clk     (enc_clk),
        .rst_n       (rst_n),
        .wr_en_i     (wr_en),
        .wr_word_i   (wr_word),
        .wr_csw_i    (wr_csw),
        .wr_eom_i    (wr_eom),
        .wr_full_o   (wr_full),
        .fifo_cnt_o  (fifo_cnt),
        .tx_busy_i   (tx_busy),
        .tx_dword_o  (tx_dword),
        .tx_csw_o    (tx_csw),
        .tx_dw_o     (tx_dw),
        .msg_done_o  (msg_done),
        .ovf_err_o   (ovf_err),
        .to_err_o    (to_err),
        .err_clr_i   (err_clr),
        .state_dbg_o (state_dbg)
    );

    // clock / reset-independent housekeeping
    always #5 enc_clk = ~enc_clk;
    assign tx_busy = enc_auto ? enc_busy : busy_man;

    always @(posedge enc_clk) begin
        cyc = cyc + 1;
        #1;
        enc_busy = enc_next;
    end

    // Monitor: scoreboard on strobes, log strobe/done cycles, encoder model decides next busy.
    always @(negedge enc_clk) begin
        if (rst_n) begin
            if (tx_csw || tx_dw) begin
                strobe_log.push_back(cyc);
                n_checks++;
                if (tx_csw && tx_dw) begin
                    n_fail++;
                    $display("FAIL strobe_excl: tx_csw=%b tx_dw=%b required not both", tx_csw, tx_dw);
                end
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_strobe: word %h csw=%b at cycle %0d, none required", tx_dword, tx_csw, cyc);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({tx_csw, tx_dword} !== exp_v) begin
                        n_fail++;
                        $display("FAIL strobe_word: got csw=%b word=%h required csw=%b word=%h",
                                 tx_csw, tx_dword, exp_v[16], exp_v[15:0]);
                    end
                end
            end
            if (msg_done) done_log.push_back(cyc);
        end
        if (enc_auto) begin
            if (tx_csw || tx_dw) enc_rem = enc_len;
            if (enc_rem > 0) begin
                enc_next = 1'b1;
                enc_rem  = enc_rem - 1;
            end else begin
                enc_next = 1'b0;
            end
        end else begin
            enc_rem  = 0;
            enc_next = 1'b0;
        end
    end

    // driver tasks
    task automatic write_word(input logic [15:0] w, input logic csw, input logic eom, input bit accept);
        @(posedge enc_clk); #1;
        wr_en = 1'b1; wr_word = w; wr_csw = csw; wr_eom = eom;
        if (accept) exp_q.push_back({csw, w});
    endtask

    task automatic wr_idle();
        @(posedge enc_clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge enc_clk); #1;
        end
    endtask

    task automatic wait_strobes(input int n, input int limit, input string name);
        int t = 0;
        while (strobe_log.size() < n && t < limit) begin
            @(posedge enc_clk); #1;
            t++;
        end
        n_checks++;
        if (strobe_log.size() < n) begin
            n_fail++;
            $display("FAIL %s: timeout, got %0d strobes required %0d", name, strobe_log.size(), n);
        end
    endtask

    task automatic wait_dones(input int n, input int limit, input string name);
        int t = 0;
        while (done_log.size() < n && t < limit) begin
            @(posedge enc_clk); #1;
            t++;
        end
        n_checks++;
        if (done_log.size() < n) begin
            n_fail++;
            $display("FAIL %s: timeout, got %0d msg_done pulses required %0d", name, done_log.size(), n);
        end
    endtask

    // tests
    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx_dword, tx_csw, tx_dw, msg_done} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_tx: got dword=%h csw=%b dw=%b done=%b required all 0", tx_dword, tx_csw, tx_dw, msg_done);
        end
        n_checks++;
        if ({ovf_err, to_err, wr_full, fifo_cnt} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got ovf=%b to=%b full=%b cnt=%0d required all 0", ovf_err, to_err, wr_full, fifo_cnt);
        end
        n_checks++;
        if (state_dbg !== S_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d required %0d", state_dbg, S_IDLE);
        end
        repeat (3) @(negedge enc_clk);
        rst_n = 1'b1;
        @(posedge enc_clk); #1;
        n_checks++;
        if (state_dbg !== S_IDLE || fifo_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_release: got state=%0d cnt=%0d required 0/0", state_dbg, fifo_cnt);
        end
    endtask

    task automatic test_single_msg();
        int base, dbase, w, s;
        enc_len = 38; enc_auto = 1'b1;
        base = strobe_log.size(); dbase = done_log.size();
        write_word(16'hF101, 1'b1, 1'b1, 1'b1);
        w = cyc;
        wr_idle();
        wait_strobes(base + 1, 10, "single_strobe");
        s = strobe_log[base];
        n_checks++;
        if (s !== w + 2) begin
            n_fail++;
            $display("FAIL single_latency: strobe at cycle %0d required %0d", s, w + 2);
        end
        wait_dones(dbase + 1, 60, "single_done");
        n_checks++;
        if (done_log[dbase] !== s + enc_len + 2) begin
            n_fail++;
            $display("FAIL single_done_time: msg_done at %0d required %0d", done_log[dbase], s + enc_len + 2);
        end
        wait_cyc(s + enc_len + 9);
        n_checks++;
        if (state_dbg !== S_GAP || tx_dword !== 16'hF101) begin
            n_fail++;
            $display("FAIL single_gap_end: state=%0d dword=%h required %0d/F101", state_dbg, tx_dword, S_GAP);
        end
        wait_cyc(s + enc_len + 10);
        n_checks++;
        if (state_dbg !== S_IDLE || done_log.size() !== dbase + 1) begin
            n_fail++;
            $display("FAIL single_idle: state=%0d dones=%0d required %0d/%0d", state_dbg, done_log.size() - dbase, S_IDLE, 1);
        end
    endtask

    task automatic test_back_to_back();
        int base, dbase, w, l;
        int s[4];
        l = 5; enc_len = l; enc_auto = 1'b1;
        base = strobe_log.size(); dbase = done_log.size();
        write_word(16'hA001, 1'b1, 1'b0, 1'b1);
        w = cyc;
        write_word(16'hA002, 1'b0, 1'b0, 1'b1);
        write_word(16'hA003, 1'b0, 1'b1, 1'b1);
        write_word(16'hB001, 1'b1, 1'b1, 1'b1);
        wr_idle();
        wait_strobes(base + 4, 150, "b2b_strobes");
        for (int i = 0; i < 4; i++) s[i] = strobe_log[base + i];
        n_checks++;
        if (s[0] !== w + 2) begin
            n_fail++;
            $display("FAIL b2b_first: strobe at %0d required %0d", s[0], w + 2);
        end
        for (int i = 1; i < 3; i++) begin
            n_checks++;
            if (s[i] !== s[i-1] + l + 3) begin
                n_fail++;
                $display("FAIL b2b_within_msg: strobe %0d at %0d required %0d", i, s[i], s[i-1] + l + 3);
            end
        end
        n_checks++;
        if (s[3] !== s[2] + l + 11) begin
            n_fail++;
            $display("FAIL b2b_gap: strobe 3 at %0d required %0d", s[3], s[2] + l + 11);
        end
        wait_cyc(s[3] + l + 12);
        n_checks++;
        if (done_log.size() !== dbase + 2 || done_log[dbase] !== s[2] + l + 2) begin
            n_fail++;
            $display("FAIL b2b_done: got %0d pulses first at %0d required 2 first at %0d",
                     done_log.size() - dbase, done_log[dbase], s[2] + l + 2);
        end
    endtask

    task automatic test_overflow();
        int base;
        enc_auto = 1'b0; busy_man = 1'b1;
        repeat (2) @(posedge enc_clk);
        #1;
        base = strobe_log.size();
        for (int k = 0; k < 9; k++) begin
            write_word(16'(16'h0C00 + k), k == 0, k == 7, k < 8);
            if (k == 7) begin
                n_checks++;
                if (fifo_cnt !== 4'd7 || wr_full !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_before_full: cnt=%0d full=%b required 7/0", fifo_cnt, wr_full);
                end
            end
            if (k == 8) begin
                n_checks++;
                if (fifo_cnt !== 4'd8 || wr_full !== 1'b1 || ovf_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_full: cnt=%0d full=%b ovf=%b required 8/1/0", fifo_cnt, wr_full, ovf_err);
                end
            end
        end
        wr_idle();
        n_checks++;
        if (ovf_err !== 1'b1 || fifo_cnt !== 4'd8 || strobe_log.size() !== base) begin
            n_fail++;
            $display("FAIL ovf_flag: ovf=%b cnt=%0d strobes=%0d required 1/8/0", ovf_err, fifo_cnt, strobe_log.size() - base);
        end
    endtask

    task automatic test_err_clr();
        @(posedge enc_clk); #1; err_clr = 1'b1;
        @(posedge enc_clk); #1; err_clr = 1'b0;
        n_checks++;
        if (ovf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL errclr_plain: ovf=%b required 0", ovf_err);
        end
        @(posedge enc_clk); #1; err_clr = 1'b1; wr_en = 1'b1; wr_word = 16'hDEAD; wr_csw = 1'b0; wr_eom = 1'b0;
        @(posedge enc_clk); #1; err_clr = 1'b0; wr_en = 1'b0;
        n_checks++;
        if (ovf_err !== 1'b1 || fifo_cnt !== 4'd8) begin
            n_fail++;
            $display("FAIL errclr_collide: ovf=%b cnt=%0d required 1/8", ovf_err, fifo_cnt);
        end
        @(posedge enc_clk); #1; err_clr = 1'b1;
        @(posedge enc_clk); #1; err_clr = 1'b0;
        n_checks++;
        if (ovf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL errclr_again: ovf=%b required 0", ovf_err);
        end
    endtask

    task automatic test_drain();
        int t = 0;
        enc_len = 3; enc_auto = 1'b1;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge enc_clk); #1;
            t++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d words still pending, required 0", exp_q.size());
        end
        repeat (20) @(posedge enc_clk);
        #1;
        n_checks++;
        if (fifo_cnt !== 4'd0 || wr_full !== 1'b0 || to_err !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_end: cnt=%0d full=%b to=%b required 0/0/0", fifo_cnt, wr_full, to_err);
        end
    endtask

    task automatic test_timeout();
        int base, w, s1;
        enc_auto = 1'b0; busy_man = 1'b0;
        base = strobe_log.size();
        write_word(16'h7E01, 1'b0, 1'b0, 1'b1);
        w = cyc;
        write_word(16'h7E02, 1'b1, 1'b1, 1'b1);
        wr_idle();
        wait_strobes(base + 1, 10, "to_first");
        s1 = strobe_log[base];
        n_checks++;
        if (s1 !== w + 2) begin
            n_fail++;
            $display("FAIL to_first_time: strobe at %0d required %0d", s1, w + 2);
        end
        wait_cyc(s1 + 4);
        n_checks++;
        if (to_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_early: to_err=%b required 0", to_err);
        end
        wait_cyc(s1 + 5);
        n_checks++;
        if (to_err !== 1'b1) begin
            n_fail++;
            $display("FAIL to_set: to_err=%b required 1", to_err);
        end
        wait_strobes(base + 2, 20, "to_second");
        n_checks++;
        if (strobe_log[base + 1] !== s1 + 6) begin
            n_fail++;
            $display("FAIL to_next_word: strobe at %0d required %0d", strobe_log[base + 1], s1 + 6);
        end
        wait_cyc(s1 + 22);
        n_checks++;
        if (state_dbg !== S_IDLE || fifo_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL to_settle: state=%0d cnt=%0d required %0d/0", state_dbg, fifo_cnt, S_IDLE);
        end
        err_clr = 1'b1;
        @(posedge enc_clk); #1; err_clr = 1'b0;
        n_checks++;
        if (to_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_clear: to_err=%b required 0", to_err);
        end
    endtask

    task automatic test_reset_mid_msg();
        int t = 0;
        int base;
        enc_len = 20; enc_auto = 1'b1;
        write_word(16'h5A00, 1'b1, 1'b0, 1'b1);
        write_word(16'h5A01, 1'b0, 1'b0, 1'b0);
        write_word(16'h5A02, 1'b0, 1'b0, 1'b0);
        write_word(16'h5A03, 1'b0, 1'b1, 1'b0);
        wr_idle();
        while (state_dbg !== S_WAIT_DONE && t < 30) begin
            @(posedge enc_clk); #1;
            t++;
        end
        n_checks++;
        if (state_dbg !== S_WAIT_DONE || fifo_cnt !== 4'd3) begin
            n_fail++;
            $display("FAIL rst_mid_setup: state=%0d cnt=%0d required %0d/3", state_dbg, fifo_cnt, S_WAIT_DONE);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx_dword, tx_csw, tx_dw, msg_done, ovf_err, to_err, wr_full, fifo_cnt} !== 26'd0 || state_dbg !== S_IDLE) begin
            n_fail++;
            $display("FAIL rst_mid_async: dword=%h csw=%b dw=%b done=%b ovf=%b to=%b full=%b cnt=%0d state=%0d required all 0",
                     tx_dword, tx_csw, tx_dw, msg_done, ovf_err, to_err, wr_full, fifo_cnt, state_dbg);
        end
        exp_q.delete();
        enc_auto = 1'b0; busy_man = 1'b0;
        repeat (2) @(negedge enc_clk);
        rst_n = 1'b1;
        @(posedge enc_clk); #1;
        base = strobe_log.size();
        repeat (20) @(posedge enc_clk);
        #1;
        n_checks++;
        if (strobe_log.size() !== base || fifo_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_mid_after: strobes=%0d cnt=%0d required 0/0", strobe_log.size() - base, fifo_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_msg();
        test_back_to_back();
        test_overflow();
        test_err_clr();
        test_drain();
        test_timeout();
        test_reset_mid_msg();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_queue: %0d words never issued, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
